tx_os_sched: RTL and testbench

- Transmit ordered-set scheduler between the TS1/TS2 generator and the 128-bit TX FIFO.
- Merges three sources onto one FIFO write port: the generator's TS beats, periodic SKP ordered sets, and EIOS bursts requested by the LTSSM.
- Holds off the generator through a stall signal and a one-entry skid buffer.
- Each FIFO write carries exactly one ordered set, so every write is an ordered-set boundary.

---
 rtl/tx_os_sched_if.sv | 44 ++++
 rtl/tx_os_sched.sv | 173 +++++++++++++++++
 tb/tb_tx_os_sched.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_os_sched_if.sv
// Ordered-set scheduler bus: generator-side TS handshake, LTSSM EIOS handshake,
// and the TX FIFO write port. The scheduler drives through "master", while the
// generator, the LTSSM and the FIFO sit on "slave".
interface tx_os_sched_if;
  logic         ts_valid;
  logic [127:0] ts;
  logic         ts_stall;
  logic         skp_en;
  logic         eios_req;
  logic         eios_ack;
  logic         fifo_full;
  logic         fifo_wr;
  logic [127:0] fifo_data;
  logic [4:0]   fifo_len;
  logic         ts_ovf;

  modport master (
    input  ts_valid,
    input  ts,
    input  skp_en,
    input  eios_req,
    input  fifo_full,
    output ts_stall,
    output eios_ack,
    output fifo_wr,
    output fifo_data,
    output fifo_len,
    output ts_ovf
  );

  modport slave (
    output ts_valid,
    output ts,
    output skp_en,
    output eios_req,
    output fifo_full,
    input  ts_stall,
    input  eios_ack,
    input  fifo_wr,
    input  fifo_data,
    input  fifo_len,
    input  ts_ovf
  );
endinterface

// File: rtl/tx_os_sched.sv
// Transmit ordered-set scheduler. Merges TS beats from the generator, periodic
// SKP ordered sets and LTSSM-requested EIOS bursts onto a single 128-bit FIFO
// write port. Each write carries exactly one ordered set. A one-entry skid
// buffer absorbs the beat that is in flight when the generator gets stalled.
module tx_os_sched #(
  parameter int unsigned SKP_INTERVAL = 1180,  // 2..65535
  parameter int unsigned EIOS_NUM     = 1      // 1..4
) (
  input logic            clk,
  input logic            rst,
  tx_os_sched_if.master  bus_io
);

  localparam logic [127:0] SkpWord  = {8'hBC, 8'h1C, 8'h1C, 8'h1C, 96'h0};
  localparam logic [127:0] EiosWord = {8'hBC, 8'h7C, 8'h7C, 8'h7C, 96'h0};
  localparam logic [4:0]   LenTs    = 5'd16;
  localparam logic [4:0]   LenOs    = 5'd4;
  localparam logic [15:0]  SkpLast  = 16'(SKP_INTERVAL - 1);
  localparam logic [1:0]   EiosLast = 2'(EIOS_NUM - 1);

  typedef enum logic [1:0] {StPass, StEios, StEi} state_e;

  state_e         state_q, state_d;
  logic           skid_vld_q, skid_vld_d;
  logic [127:0]   skid_q, skid_d;
  logic           skp_pend_q, skp_pend_d;
  logic [15:0]    skp_cnt_q, skp_cnt_d;
  logic [1:0]     eios_cnt_q, eios_cnt_d;
  logic           fifo_wr_q, fifo_wr_d;
  logic [127:0]   fifo_data_q, fifo_data_d;
  logic [4:0]     fifo_len_q, fifo_len_d;
  logic           ts_stall_q, ts_stall_d;
  logic           eios_ack_q, eios_ack_d;
  logic           ts_ovf_q, ts_ovf_d;

  logic           skp_wrap;
  logic           skid_wr;
  logic           direct_wr;

  // Next-state: SKP timer, write arbitration, skid capture and stall generation.
  always_comb begin
    state_d     = state_q;
    skid_vld_d  = skid_vld_q;
    skid_d      = skid_q;
    skp_pend_d  = skp_pend_q;
    skp_cnt_d   = skp_cnt_q;
    eios_cnt_d  = eios_cnt_q;
    fifo_wr_d   = 1'b0;
    fifo_data_d = fifo_data_q;
    fifo_len_d  = fifo_len_q;
    ts_ovf_d    = ts_ovf_q;
    skp_wrap    = 1'b0;
    skid_wr     = 1'b0;
    direct_wr   = 1'b0;

    // SKP interval timer; disabling it restarts the interval.
    if (bus_io.skp_en) begin
      if (skp_cnt_q == SkpLast) begin
        skp_cnt_d = '0;
        skp_wrap  = 1'b1;
      end else begin
        skp_cnt_d = skp_cnt_q + 16'd1;
      end
    end else begin
      skp_cnt_d = '0;
    end

    case (state_q)
      StPass: begin
        if (bus_io.eios_req) begin
          state_d = StEios;
        end else if (!bus_io.fifo_full) begin
          if (skp_pend_q) begin
            fifo_wr_d   = 1'b1;
            fifo_data_d = SkpWord;
            fifo_len_d  = LenOs;
            skp_pend_d  = 1'b0;
          end else if (skid_vld_q) begin
            fifo_wr_d   = 1'b1;
            fifo_data_d = skid_q;
            fifo_len_d  = LenTs;
            skid_wr     = 1'b1;
          end else if (bus_io.ts_valid) begin
            fifo_wr_d   = 1'b1;
            fifo_data_d = bus_io.ts;
            fifo_len_d  = LenTs;
            direct_wr   = 1'b1;
          end
        end
      end
      StEios: begin
        if (!bus_io.fifo_full) begin
          fifo_wr_d   = 1'b1;
          fifo_data_d = EiosWord;
          fifo_len_d  = LenOs;
          if (eios_cnt_q == EiosLast) begin
            eios_cnt_d = '0;
            state_d    = StEi;
          end else begin
            eios_cnt_d = eios_cnt_q + 2'd1;
          end
        end
      end
      StEi: begin
        if (!bus_io.eios_req) begin
          state_d = StPass;
        end
      end
      default: state_d = StPass;
    endcase

    // A fresh wrap re-arms the pending flag even if the old one was just sent.
    if (skp_wrap) begin
      skp_pend_d = 1'b1;
    end

    // Skid: freed by its own write, refilled by any beat not written directly.
    if (skid_wr) begin
      skid_vld_d = 1'b0;
    end
    if (bus_io.ts_valid && !direct_wr) begin
      if (!skid_vld_q || skid_wr) begin
        skid_d     = bus_io.ts;
        skid_vld_d = 1'b1;
      end else begin
        ts_ovf_d = 1'b1;
      end
    end

    eios_ack_d = (state_d == StEi);
    ts_stall_d = bus_io.fifo_full | skid_vld_d | (state_q != StPass) |
                 bus_io.eios_req | skp_pend_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StPass;
      skid_vld_q  <= 1'b0;
      skid_q      <= '0;
      skp_pend_q  <= 1'b0;
      skp_cnt_q   <= '0;
      eios_cnt_q  <= '0;
      fifo_wr_q   <= 1'b0;
      fifo_data_q <= '0;
      fifo_len_q  <= '0;
      ts_stall_q  <= 1'b1;
      eios_ack_q  <= 1'b0;
      ts_ovf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      skid_vld_q  <= skid_vld_d;
      skid_q      <= skid_d;
      skp_pend_q  <= skp_pend_d;
      skp_cnt_q   <= skp_cnt_d;
      eios_cnt_q  <= eios_cnt_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_data_q <= fifo_data_d;
      fifo_len_q  <= fifo_len_d;
      ts_stall_q  <= ts_stall_d;
      eios_ack_q  <= eios_ack_d;
      ts_ovf_q    <= ts_ovf_d;
    end
  end

  assign bus_io.ts_stall  = ts_stall_q;
  assign bus_io.eios_ack  = eios_ack_q;
  assign bus_io.fifo_wr   = fifo_wr_q;
  assign bus_io.fifo_data = fifo_data_q;
  assign bus_io.fifo_len  = fifo_len_q;
  assign bus_io.ts_ovf    = ts_ovf_q;

endmodule

// File: tb/tb_tx_os_sched.sv
// Bench for tx_os_sched: SKP_INTERVAL=8, EIOS_NUM=2. TS beats are queued when
// driven and compared in order as they appear on the FIFO port.
module tb_tx_os_sched;

  localparam logic [127:0] SkpWord  = {8'hBC, 8'h1C, 8'h1C, 8'h1C, 96'h0};
  localparam logic [127:0] EiosWord = {8'hBC, 8'h7C, 8'h7C, 8'h7C, 96'h0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_os_sched_if bus ();

  tx_os_sched #(
    .SKP_INTERVAL(8),
    .EIOS_NUM    (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus.master)
  );

  typedef struct {
    logic full;
    logic eios;
    logic wr;
    logic stall;
    logic ack;
  } vec_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_eios  = 0;
  logic [127:0] exp_q[$];
  bit           gen_on  = 1'b0;
  logic [127:0] last_ts;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Generator model: presents a fresh beat unless stalled (or told to ignore it).
  task automatic gen_drive(input bit respect);
    if (gen_on && (!respect || !bus.ts_stall)) begin
      bus.ts_valid = 1'b1;
      bus.ts       = rand128();
      last_ts      = bus.ts;
      exp_q.push_back(bus.ts);
    end else begin
      bus.ts_valid = 1'b0;
    end
  endtask

  // FIFO-side monitor: TS writes must match the queue in order; 4-byte writes
  // must be SKP or EIOS.
  always @(negedge clk) begin
    if (!rst && bus.fifo_wr) begin
      if (bus.fifo_len == 5'd16) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_extra: got TS write %0h, want no write", bus.fifo_data);
        end else begin
          chk("sb_ts_data", bus.fifo_data, exp_q.pop_front());
        end
      end else if (bus.fifo_len == 5'd4) begin
        if (bus.fifo_data == EiosWord) n_eios++;
        else chk("os_word", bus.fifo_data, SkpWord);
      end else begin
        chk("fifo_len", 128'(bus.fifo_len), 128'd16);
      end
    end
  end

  vec_t tbl[17];
  int   last_skp;
  int   n_skp;
  bit   expect_skid;

  initial begin
    // full, eios_req -> fifo_wr, ts_stall, eios_ack after the edge
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    rst           = 1'b1;
    bus.ts_valid  = 1'b0;
    bus.ts        = '0;
    bus.skp_en    = 1'b0;
    bus.eios_req  = 1'b0;
    bus.fifo_full = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst ts_stall", 128'(bus.ts_stall), 128'd1);
    chk("rst eios_ack", 128'(bus.eios_ack), 128'd0);
    chk("rst fifo_wr", 128'(bus.fifo_wr), 128'd0);
    chk("rst fifo_data", bus.fifo_data, 128'd0);
    chk("rst fifo_len", 128'(bus.fifo_len), 128'd0);
    chk("rst ts_ovf", 128'(bus.ts_ovf), 128'd0);

    rst = 1'b0;
    tick();

    // Steady stream: 1-cycle latency, no stall
    gen_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      gen_drive(1'b1);
      tick();
      chk($sformatf("A%0d wr", i), 128'(bus.fifo_wr), 128'd1);
      chk($sformatf("A%0d data", i), bus.fifo_data, last_ts);
      chk($sformatf("A%0d len", i), 128'(bus.fifo_len), 128'd16);
      chk($sformatf("A%0d stall", i), 128'(bus.ts_stall), 128'd0);
    end
    chk("A ovf", 128'(bus.ts_ovf), 128'd0);

    // FIFO-full hold then EIOS burst / electrical idle, cycle by cycle
    for (int r = 0; r < 17; r++) begin
      bus.fifo_full = tbl[r].full;
      bus.eios_req  = tbl[r].eios;
      gen_drive(1'b1);
      tick();
      chk($sformatf("T%0d wr", r), 128'(bus.fifo_wr), 128'(tbl[r].wr));
      chk($sformatf("T%0d stall", r), 128'(bus.ts_stall), 128'(tbl[r].stall));
      chk($sformatf("T%0d ack", r), 128'(bus.eios_ack), 128'(tbl[r].ack));
    end
    chk("eios count", 128'(n_eios), 128'd2);

    // SKP every 8 cycles, displaced beat written from the skid right after
    bus.skp_en  = 1'b1;
    last_skp    = -1;
    n_skp       = 0;
    expect_skid = 1'b0;
    for (int i = 0; i < 34; i++) begin
      gen_drive(1'b1);
      tick();
      if (bus.fifo_wr && bus.fifo_len == 5'd4) begin
        chk("C skp word", bus.fifo_data, SkpWord);
        if (last_skp >= 0) chk("C skp period", 128'(i - last_skp), 128'd8);
        last_skp    = i;
        n_skp++;
        expect_skid = 1'b1;
      end else if (expect_skid) begin
        chk("C skid after skp", 128'({bus.fifo_wr, bus.fifo_len}), 128'({1'b1, 5'd16}));
        expect_skid = 1'b0;
      end
    end
    chk("C skp count", 128'(n_skp), 128'd4);

    gen_on       = 1'b0;
    bus.ts_valid = 1'b0;
    bus.skp_en   = 1'b0;
    tick();
    tick();
    tick();

    // Generator ignores stall while FIFO is full: first beat kept, rest dropped
    bus.fifo_full = 1'b1;
    bus.ts_valid  = 1'b1;
    bus.ts        = rand128();
    last_ts       = bus.ts;
    exp_q.push_back(bus.ts);
    tick();
    chk("D ovf early", 128'(bus.ts_ovf), 128'd0);
    chk("D wr while full", 128'(bus.fifo_wr), 128'd0);
    bus.ts = rand128();
    tick();
    chk("D ovf set", 128'(bus.ts_ovf), 128'd1);
    chk("D stall", 128'(bus.ts_stall), 128'd1);
    bus.ts = rand128();
    tick();
    bus.ts_valid  = 1'b0;
    bus.fifo_full = 1'b0;
    tick();
    chk("D skid wr", 128'(bus.fifo_wr), 128'd1);
    chk("D skid data", bus.fifo_data, last_ts);
    tick();
    tick();
    tick();
    chk("D ovf sticky", 128'(bus.ts_ovf), 128'd1);

    // Reset mid EIOS burst with an SKP pending
    bus.skp_en    = 1'b1;
    bus.eios_req  = 1'b1;
    bus.fifo_full = 1'b1;
    repeat (9) tick();
    bus.fifo_full = 1'b0;
    tick();
    chk("E eios wr", 128'(bus.fifo_wr), 128'd1);
    chk("E eios data", bus.fifo_data, EiosWord);
    rst = 1'b1;
    tick();
    chk("E rst ts_stall", 128'(bus.ts_stall), 128'd1);
    chk("E rst eios_ack", 128'(bus.eios_ack), 128'd0);
    chk("E rst fifo_wr", 128'(bus.fifo_wr), 128'd0);
    chk("E rst fifo_data", bus.fifo_data, 128'd0);
    chk("E rst fifo_len", 128'(bus.fifo_len), 128'd0);
    chk("E rst ts_ovf", 128'(bus.ts_ovf), 128'd0);
    rst          = 1'b0;
    bus.eios_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i < 8) begin
        chk($sformatf("E%0d no skp", i), 128'(bus.fifo_wr), 128'd0);
      end else begin
        chk("E skp wr", 128'(bus.fifo_wr), 128'd1);
        chk("E skp len", 128'(bus.fifo_len), 128'd4);
        chk("E skp data", bus.fifo_data, SkpWord);
      end
    end

    bus.skp_en = 1'b0;
    tick();
    tick();
    chk("sb drained", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
